// File: rtl/fetch_pc_scheduler.sv
// Next-PC command generator: redirect arbitration, debug halt/step/resume, fetch-flush window.
// Zero latency (outputs combinational from state + inputs); a redirect blocked by !i_mem_ready parks in a pending slot.
module fetch_pc_scheduler #(
  parameter int ADDRESS_BITS = 20,
  parameter int FLUSH_CYCLES = 2,
  parameter int COUNT_BITS   = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    trap_valid,
  input  logic [ADDRESS_BITS-1:0] trap_PC,
  input  logic                    branch_valid,
  input  logic [ADDRESS_BITS-1:0] branch_target,
  input  logic                    jump_valid,
  input  logic [ADDRESS_BITS-1:0] jump_target,
  input  logic                    stall_hazard,
  input  logic                    i_mem_ready,
  input  logic                    halt_req,
  input  logic                    step_req,
  input  logic                    resume_req,
  output logic [1:0]              next_PC_select,
  output logic [ADDRESS_BITS-1:0] target_PC,
  output logic                    flush_fetch,
  output logic                    halted,
  output logic [COUNT_BITS-1:0]   redirect_count
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_HALT   = 2'd1;
  localparam logic [1:0] ST_STEP   = 2'd2;
  localparam logic [1:0] SEL_INCR  = 2'b00;
  localparam logic [1:0] SEL_STALL = 2'b01;
  localparam logic [1:0] SEL_JUMP  = 2'b10;
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  logic [1:0]              r_state;
  logic                    r_pend_vld;
  logic [1:0]              r_pend_prio;
  logic [ADDRESS_BITS-1:0] r_pend_tgt;
  logic [3:0]              r_flush_cnt;
  logic [COUNT_BITS-1:0]   r_redirect_count;

  logic                    w_new_vld;
  logic [1:0]              w_new_prio;
  logic [ADDRESS_BITS-1:0] w_new_tgt;
  logic                    w_take_new;
  logic                    w_cand_vld;
  logic [1:0]              w_cand_prio;
  logic [ADDRESS_BITS-1:0] w_cand_tgt;
  logic                    w_issue;
  logic                    w_hold;
  logic [1:0]              w_sel;
  logic [1:0]              w_state_nxt;

  always_comb begin
    w_new_vld  = 1'b1;
    w_new_prio = 2'd0;
    w_new_tgt  = '0;
    if (trap_valid) begin
      w_new_prio = 2'd3;
      w_new_tgt  = trap_PC;
    end else if (branch_valid) begin
      w_new_prio = 2'd2;
      w_new_tgt  = branch_target;
    end else if (jump_valid) begin
      w_new_prio = 2'd1;
      w_new_tgt  = jump_target;
    end else begin
      w_new_vld  = 1'b0;
    end
  end

  // A fresh request displaces the parked one on equal priority: the newer target wins.
  assign w_take_new  = w_new_vld && (!r_pend_vld || (w_new_prio >= r_pend_prio));
  assign w_cand_vld  = w_new_vld | r_pend_vld;
  assign w_cand_prio = w_take_new ? w_new_prio : r_pend_prio;
  assign w_cand_tgt  = w_take_new ? w_new_tgt : r_pend_tgt;
  assign w_issue     = w_cand_vld & i_mem_ready;
  assign w_hold      = stall_hazard | !i_mem_ready | (r_state == ST_HALT);

  always_comb begin
    if (w_issue)                 w_sel = SEL_JUMP;
    else if (w_cand_vld | w_hold) w_sel = SEL_STALL;
    else                         w_sel = SEL_INCR;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:  if (halt_req) w_state_nxt = ST_HALT;
      ST_HALT: begin
        if (resume_req) begin
          if (!halt_req) w_state_nxt = ST_RUN;
        end else if (step_req) begin
          w_state_nxt = ST_STEP;
        end
      end
      // One advancing cycle (increment or redirect) completes the step.
      ST_STEP: if (w_sel != SEL_STALL) w_state_nxt = ST_HALT;
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state          <= ST_RUN;
      r_pend_vld       <= 1'b0;
      r_pend_prio      <= 2'd0;
      r_pend_tgt       <= '0;
      r_flush_cnt      <= 4'd0;
      r_redirect_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_issue) begin
        r_pend_vld <= 1'b0;
      end else if (w_cand_vld) begin
        r_pend_vld  <= 1'b1;
        r_pend_prio <= w_cand_prio;
        r_pend_tgt  <= w_cand_tgt;
      end
      if (w_issue)                r_flush_cnt <= FLUSH_LOAD;
      else if (r_flush_cnt != 4'd0) r_flush_cnt <= r_flush_cnt - 4'd1;
      if (w_issue && (r_redirect_count != '1))
        r_redirect_count <= r_redirect_count + COUNT_BITS'(1);
    end
  end

  assign next_PC_select = reset ? w_sel : SEL_STALL;
  assign target_PC      = (reset && w_issue) ? w_cand_tgt : '0;
  assign flush_fetch    = (r_flush_cnt != 4'd0);
  assign halted         = (r_state == ST_HALT);
  assign redirect_count = r_redirect_count;

endmodule

// File: tb/tb_fetch_pc_scheduler.sv
// Directed bench for fetch_pc_scheduler with a queue-based scoreboard; flush and count tracked by a small model.
module tb_fetch_pc_scheduler;

  localparam int AB = 20;
  localparam int CB = 4;

  logic          clock;
  logic          reset;
  logic          trap_valid, branch_valid, jump_valid;
  logic [AB-1:0] trap_PC, branch_target, jump_target;
  logic          stall_hazard, i_mem_ready, halt_req, step_req, resume_req;
  logic [1:0]    next_PC_select;
  logic [AB-1:0] target_PC;
  logic          flush_fetch, halted;
  logic [CB-1:0] redirect_count;

  fetch_pc_scheduler #(.ADDRESS_BITS(AB), .FLUSH_CYCLES(2), .COUNT_BITS(CB)) dut (
    .clock(clock), .reset(reset),
    .trap_valid(trap_valid), .trap_PC(trap_PC),
    .branch_valid(branch_valid), .branch_target(branch_target),
    .jump_valid(jump_valid), .jump_target(jump_target),
    .stall_hazard(stall_hazard), .i_mem_ready(i_mem_ready),
    .halt_req(halt_req), .step_req(step_req), .resume_req(resume_req),
    .next_PC_select(next_PC_select), .target_PC(target_PC),
    .flush_fetch(flush_fetch), .halted(halted), .redirect_count(redirect_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0]    sel;
    logic [AB-1:0] tgt;
    logic          flush;
    logic          hlt;
    logic [CB-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   m_flush = 0;
  int   m_cnt = 0;

  task automatic cmp(input string tag, input string what, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s.%s got=%0h want=%0h", tag, what, got, want);
    end
  endtask

  // Inputs are already driven; expectation is queued, compared mid-cycle, then the clock advances.
  task automatic chk(input string tag, input logic [1:0] sel, input logic [AB-1:0] tgt, input logic hlt);
    exp_t e;
    if (!reset) begin
      m_flush = 0;
      m_cnt   = 0;
    end
    e.sel   = sel;
    e.tgt   = tgt;
    e.flush = (m_flush != 0);
    e.hlt   = hlt;
    e.cnt   = CB'(m_cnt);
    q.push_back(e);
    #2;
    e = q.pop_front();
    cmp(tag, "sel",   32'(next_PC_select), 32'(e.sel));
    cmp(tag, "tgt",   32'(target_PC),      32'(e.tgt));
    cmp(tag, "flush", 32'(flush_fetch),    32'(e.flush));
    cmp(tag, "halt",  32'(halted),         32'(e.hlt));
    cmp(tag, "cnt",   32'(redirect_count), 32'(e.cnt));
    if (reset) begin
      if (sel == 2'b10) begin
        m_flush = 2;
        if (m_cnt < (1 << CB) - 1) m_cnt++;
      end else if (m_flush > 0) begin
        m_flush--;
      end
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    trap_valid = 0; branch_valid = 0; jump_valid = 0;
    trap_PC = '0; branch_target = '0; jump_target = '0;
    stall_hazard = 0; i_mem_ready = 1; halt_req = 0; step_req = 0; resume_req = 0;
    #1;
    trap_valid = 1; trap_PC = 20'h00123;
    chk("reset", 2'b01, 20'h0, 0);
    trap_valid = 0;
    reset = 1'b1;

    for (int i = 0; i < 3; i++) chk("idle", 2'b00, 20'h0, 0);

    // All three sources at once: trap wins.
    trap_valid = 1; trap_PC = 20'h00100;
    branch_valid = 1; branch_target = 20'h00200;
    jump_valid = 1; jump_target = 20'h00300;
    chk("prio", 2'b10, 20'h00100, 0);
    trap_valid = 0; branch_valid = 0; jump_valid = 0;
    chk("flush1", 2'b00, 20'h0, 0);
    chk("flush2", 2'b00, 20'h0, 0);
    chk("flush3", 2'b00, 20'h0, 0);

    // Backpressured branch parks; a lower-priority jump cannot displace it.
    i_mem_ready = 0; branch_valid = 1; branch_target = 20'h00040;
    chk("bp1", 2'b01, 20'h0, 0);
    branch_valid = 0; jump_valid = 1; jump_target = 20'h00300;
    chk("bp2", 2'b01, 20'h0, 0);
    jump_valid = 0;
    chk("bp3", 2'b01, 20'h0, 0);
    i_mem_ready = 1;
    chk("bp_go", 2'b10, 20'h00040, 0);
    chk("bp_after", 2'b00, 20'h0, 0);
    chk("bp_after2", 2'b00, 20'h0, 0);

    // Debug halt / step / resume.
    halt_req = 1;
    chk("halt_req", 2'b00, 20'h0, 0);
    chk("halted", 2'b01, 20'h0, 1);
    step_req = 1;
    chk("step_req", 2'b01, 20'h0, 1);
    step_req = 0;
    chk("step_go", 2'b00, 20'h0, 0);
    chk("step_back", 2'b01, 20'h0, 1);
    step_req = 1;
    chk("step2_req", 2'b01, 20'h0, 1);
    step_req = 0; stall_hazard = 1;
    chk("step_stall", 2'b01, 20'h0, 0);
    stall_hazard = 0;
    chk("step2_go", 2'b00, 20'h0, 0);
    chk("step2_back", 2'b01, 20'h0, 1);
    resume_req = 1;
    chk("resume_hold", 2'b01, 20'h0, 1);
    halt_req = 0; step_req = 1;
    chk("resume", 2'b01, 20'h0, 1);
    resume_req = 0; step_req = 0;
    chk("running", 2'b00, 20'h0, 0);

    // Redirect beats hazard.
    stall_hazard = 1; branch_valid = 1; branch_target = 20'h00080;
    chk("haz_br", 2'b10, 20'h00080, 0);
    branch_valid = 0;
    chk("haz_only", 2'b01, 20'h0, 0);
    stall_hazard = 0;
    chk("haz_clear", 2'b00, 20'h0, 0);
    chk("haz_clear2", 2'b00, 20'h0, 0);

    // Reset mid-operation drops the parked redirect.
    i_mem_ready = 0; branch_valid = 1; branch_target = 20'h00044;
    chk("park", 2'b01, 20'h0, 0);
    branch_valid = 0; reset = 1'b0;
    chk("mid_rst", 2'b01, 20'h0, 0);
    reset = 1'b1; i_mem_ready = 1;
    chk("post_rst", 2'b00, 20'h0, 0);

    // Saturation of the redirect counter.
    for (int i = 0; i < 17; i++) begin
      jump_valid = 1; jump_target = AB'(20'h01000 + i);
      chk("sat", 2'b10, AB'(20'h01000 + i), 0);
    end
    jump_valid = 0;
    chk("sat_end", 2'b00, 20'h0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
